// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM states and the
// row/column to digit keymap.
package keypad_scanner_pkg;

    localparam logic [3:0] NOKEY_CODE = 4'd10;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } key_dec_t;

    // Exactly one low column on a digit position is a valid sample; '*', '#'
    // and multi-column patterns decode as invalid.
    function automatic key_dec_t decode_key(input logic [1:0] row, input logic [2:0] col_s);
        key_dec_t   dec;
        logic       one_low;
        logic [3:0] col_num;
        logic [3:0] row_num;
        dec     = '{valid: 1'b0, digit: NOKEY_CODE};
        one_low = 1'b1;
        col_num = '0;
        row_num = {2'b00, row};
        case (col_s)
            3'b110:  col_num = 4'd0;
            3'b101:  col_num = 4'd1;
            3'b011:  col_num = 4'd2;
            default: one_low = 1'b0;
        endcase
        if (one_low) begin
            if (row == 2'd3) begin
                if (col_num == 4'd1) begin
                    dec.valid = 1'b1;
                    dec.digit = 4'd0;
                end
            end else begin
                dec.valid = 1'b1;
                dec.digit = row_num * 4'd3 + col_num + 4'd1;
            end
        end
        return dec;
    endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column inputs; resets to
// the idle (all pulled-up) level.
module col_sync #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce; presents a steady
// digit code on key and a one-clock strobe per accepted press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter logic [3:0]  NOKEY          = NOKEY_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_TICKS);

    logic [2:0]  col_s;
    scan_state_t state_q, state_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [2:0]  cap_col_q, cap_col_d;
    logic [3:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]  key_q, key_d;
    logic        strobe_q, strobe_d;
    logic [3:0]  cnt_inc;
    key_dec_t    dec;

    col_sync #(.WIDTH(3)) u_col_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_n),
        .q     (col_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            row_idx_q <= '0;
            cap_col_q <= '1;
            deb_cnt_q <= '0;
            key_q     <= NOKEY;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            cap_col_q <= cap_col_d;
            deb_cnt_q <= deb_cnt_d;
            key_q     <= key_d;
            strobe_q  <= strobe_d;
        end
    end

    // Saturating increment: the counter must never wrap back below the target.
    assign cnt_inc = (deb_cnt_q == 4'hF) ? deb_cnt_q : deb_cnt_q + 4'd1;
    assign dec     = decode_key(row_idx_q, col_s);

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        cap_col_d = cap_col_q;
        deb_cnt_d = deb_cnt_q;
        key_d     = key_q;
        strobe_d  = 1'b0;
        if (scan_tick) begin
            case (state_q)
                SCAN: begin
                    if (dec.valid) begin
                        cap_col_d = col_s;
                        deb_cnt_d = 4'd1;
                        state_d   = DEB_PRESS;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEB_PRESS: begin
                    if (col_s == cap_col_q) begin
                        deb_cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TARGET) begin
                            state_d  = PRESSED;
                            key_d    = dec.digit;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        deb_cnt_d = '0;
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                PRESSED: begin
                    if (col_s != cap_col_q) begin
                        state_d   = DEB_RELEASE;
                        deb_cnt_d = (col_s == 3'b111) ? 4'd1 : 4'd0;
                    end
                end
                DEB_RELEASE: begin
                    if (col_s == 3'b111) begin
                        deb_cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TARGET) begin
                            state_d   = SCAN;
                            key_d     = NOKEY;
                            deb_cnt_d = '0;
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else if (col_s == cap_col_q) begin
                        // Bounce back to the held key: resume without a second strobe.
                        state_d   = PRESSED;
                        deb_cnt_d = '0;
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    assign row_n      = ~(4'b0001 << row_idx_q);
    assign key        = key_q;
    assign key_strobe = strobe_q;

endmodule
